// File: rtl/seg7_scan_ctrl_if.sv
// Register-write bus for the seven-segment scan controller.
// The master drives single-cycle write strobes; the slave answers each with a one-cycle ack.
interface seg7_scan_ctrl_if;
    logic       BUS_WE;
    logic [1:0] BUS_ADDR;
    logic [7:0] BUS_DATA;
    logic       BUS_ACK;

    modport master (
        output BUS_WE,
        output BUS_ADDR,
        output BUS_DATA,
        input  BUS_ACK
    );

    modport slave (
        input  BUS_WE,
        input  BUS_ADDR,
        input  BUS_DATA,
        output BUS_ACK
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Four-digit seven-segment scan controller.
// A prescaler advances a 2-bit digit index. Digit nibbles and dot bits come from
// active registers. With SYNC set, those registers reload from shadow copies only
// at the frame wrap (index 3 -> 0).
module seg7_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic              CLK100_IN,
    input  logic              rst_n,
    input  logic              ENABLE,
    seg7_scan_ctrl_if.slave   bus,
    output logic [1:0]        SEG_SELECT_OUT,
    output logic [3:0]        BIN_OUT,
    output logic              DOT_OUT,
    output logic              FRAME_DONE
);

    localparam int unsigned      CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      shadow_dig_q, shadow_dig_d;
    logic [3:0]       shadow_dot_q, shadow_dot_d;
    logic [15:0]      act_dig_q, act_dig_d;
    logic [3:0]       act_dot_q, act_dot_d;
    logic             sync_q, sync_d;
    logic             freeze_q, freeze_d;
    logic             ack_q, ack_d;
    logic             wrap_q, wrap_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       bin_q, bin_d;
    logic             dot_q, dot_d;
    logic             frame_done_q, frame_done_d;

    logic             tick;
    logic             advance;
    logic             wrap;

    // Prescaler tick, digit-index advance and frame-wrap detection
    always_comb begin
        tick    = ENABLE && (cnt_q == CNT_MAX);
        advance = tick && !freeze_q;
        wrap    = advance && (idx_q == 2'd3);

        cnt_d = cnt_q;
        if (ENABLE) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end

        idx_d = advance ? idx_q + 2'd1 : idx_q;
    end

    // Register file: shadow/active/control updates and write acknowledge
    always_comb begin
        shadow_dig_d = shadow_dig_q;
        shadow_dot_d = shadow_dot_q;
        sync_d       = sync_q;
        freeze_d     = freeze_q;
        ack_d        = bus.BUS_WE;
        // Wrap commit reads the pre-write shadow. A same-edge write lands in the
        // shadow now and reaches the active copy at the following wrap.
        act_dig_d    = wrap ? shadow_dig_q : act_dig_q;
        act_dot_d    = wrap ? shadow_dot_q : act_dot_q;

        if (bus.BUS_WE) begin
            unique case (bus.BUS_ADDR)
                2'd0: begin
                    shadow_dig_d[7:0] = bus.BUS_DATA;
                    if (!sync_q) act_dig_d[7:0] = bus.BUS_DATA;
                end
                2'd1: begin
                    shadow_dig_d[15:8] = bus.BUS_DATA;
                    if (!sync_q) act_dig_d[15:8] = bus.BUS_DATA;
                end
                2'd2: begin
                    shadow_dot_d = bus.BUS_DATA[3:0];
                    if (!sync_q) act_dot_d = bus.BUS_DATA[3:0];
                end
                default: begin
                    sync_d   = bus.BUS_DATA[0];
                    freeze_d = bus.BUS_DATA[1];
                end
            endcase
        end
    end

    // Output stage: advances only while enabled so that outputs hold when scanning is paused
    always_comb begin
        sel_d        = sel_q;
        bin_d        = bin_q;
        dot_d        = dot_q;
        wrap_d       = wrap_q;
        frame_done_d = 1'b0;
        if (ENABLE) begin
            sel_d        = idx_q;
            bin_d        = act_dig_q[{idx_q, 2'b00} +: 4];
            dot_d        = act_dot_q[idx_q];
            wrap_d       = wrap;
            frame_done_d = wrap_q;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge CLK100_IN or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_dig_q <= '0;
            shadow_dot_q <= '0;
            act_dig_q    <= '0;
            act_dot_q    <= '0;
            sync_q       <= 1'b0;
            freeze_q     <= 1'b0;
            ack_q        <= 1'b0;
            wrap_q       <= 1'b0;
            sel_q        <= '0;
            bin_q        <= '0;
            dot_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_dig_q <= shadow_dig_d;
            shadow_dot_q <= shadow_dot_d;
            act_dig_q    <= act_dig_d;
            act_dot_q    <= act_dot_d;
            sync_q       <= sync_d;
            freeze_q     <= freeze_d;
            ack_q        <= ack_d;
            wrap_q       <= wrap_d;
            sel_q        <= sel_d;
            bin_q        <= bin_d;
            dot_q        <= dot_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.BUS_ACK     = ack_q;
    assign SEG_SELECT_OUT  = sel_q;
    assign BIN_OUT         = bin_q;
    assign DOT_OUT         = dot_q;
    assign FRAME_DONE      = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl.
// Directed scenarios are followed by randomized traffic. Every output is compared
// each cycle against a reference model built from digit arrays and integer counters.
module tb_seg7_scan_ctrl;

    localparam int DIV = 4;

    logic       CLK100_IN = 1'b0;
    logic       rst_n     = 1'b0;
    logic       ENABLE    = 1'b0;
    logic [1:0] SEG_SELECT_OUT;
    logic [3:0] BIN_OUT;
    logic       DOT_OUT;
    logic       FRAME_DONE;

    seg7_scan_ctrl_if bus ();

    seg7_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
        .CLK100_IN      (CLK100_IN),
        .rst_n          (rst_n),
        .ENABLE         (ENABLE),
        .bus            (bus),
        .SEG_SELECT_OUT (SEG_SELECT_OUT),
        .BIN_OUT        (BIN_OUT),
        .DOT_OUT        (DOT_OUT),
        .FRAME_DONE     (FRAME_DONE)
    );

    always #5 CLK100_IN = ~CLK100_IN;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    endtask

    // Reference model: scan position as integers, digit and dot values as arrays
    int m_presc, m_idx, m_sync, m_freeze, m_wpend;
    int m_sh_dig[4], m_act_dig[4], m_sh_dot[4], m_act_dot[4];
    int exp_sel, exp_bin, exp_dot, exp_fd, exp_ack;
    bit m_tick, m_adv, m_wrap;
    int m_data;

    always @(posedge CLK100_IN or negedge rst_n) begin
        if (!rst_n) begin
            m_presc = 0; m_idx = 0; m_sync = 0; m_freeze = 0; m_wpend = 0;
            for (int i = 0; i < 4; i++) begin
                m_sh_dig[i] = 0; m_act_dig[i] = 0; m_sh_dot[i] = 0; m_act_dot[i] = 0;
            end
            exp_sel = 0; exp_bin = 0; exp_dot = 0; exp_fd = 0; exp_ack = 0;
        end else begin
            m_tick = ENABLE && (m_presc == DIV - 1);
            m_adv  = m_tick && (m_freeze == 0);
            m_wrap = m_adv && (m_idx == 3);
            if (ENABLE) begin
                exp_sel = m_idx;
                exp_bin = m_act_dig[m_idx];
                exp_dot = m_act_dot[m_idx];
                exp_fd  = m_wpend;
                m_wpend = m_wrap;
            end else begin
                exp_fd = 0;
            end
            exp_ack = bus.BUS_WE;
            if (m_wrap) begin
                for (int i = 0; i < 4; i++) begin
                    m_act_dig[i] = m_sh_dig[i];
                    m_act_dot[i] = m_sh_dot[i];
                end
            end
            if (bus.BUS_WE) begin
                m_data = int'(bus.BUS_DATA);
                case (bus.BUS_ADDR)
                    2'd0, 2'd1: begin
                        m_sh_dig[2*bus.BUS_ADDR]     = m_data % 16;
                        m_sh_dig[2*bus.BUS_ADDR + 1] = m_data / 16;
                        if (m_sync == 0) begin
                            m_act_dig[2*bus.BUS_ADDR]     = m_data % 16;
                            m_act_dig[2*bus.BUS_ADDR + 1] = m_data / 16;
                        end
                    end
                    2'd2: begin
                        for (int i = 0; i < 4; i++) begin
                            m_sh_dot[i] = (m_data >> i) & 1;
                            if (m_sync == 0) m_act_dot[i] = (m_data >> i) & 1;
                        end
                    end
                    default: begin
                        m_sync   = m_data & 1;
                        m_freeze = (m_data >> 1) & 1;
                    end
                endcase
            end
            if (ENABLE) m_presc = m_tick ? 0 : m_presc + 1;
            if (m_adv) m_idx = (m_idx + 1) % 4;
        end
    end

    // Compare every output against the model away from the active edge
    always @(negedge CLK100_IN) begin
        if (chk_en) begin
            check_eq("seg_select", 32'(SEG_SELECT_OUT), exp_sel);
            check_eq("bin_out",    32'(BIN_OUT),        exp_bin);
            check_eq("dot_out",    32'(DOT_OUT),        exp_dot);
            check_eq("frame_done", 32'(FRAME_DONE),     exp_fd);
            check_eq("bus_ack",    32'(bus.BUS_ACK),    exp_ack);
        end
    end

    task automatic cyc();
        @(posedge CLK100_IN);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        bus.BUS_ADDR = a;
        bus.BUS_DATA = d;
        bus.BUS_WE   = 1'b1;
        cyc();
        bus.BUS_WE   = 1'b0;
    endtask

    // Wait for the model index to reach target; with pre_wrap, also wait until the next edge is a tick
    task automatic wait_idx(input int target, input bit pre_wrap);
        int n;
        n = 0;
        while (!((m_idx == target) && (!pre_wrap || m_presc == DIV - 1)) && n < 100) begin
            cyc();
            n++;
        end
        if (n >= 100) check_eq("wait_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bus.BUS_WE   = 1'b0;
        bus.BUS_ADDR = '0;
        bus.BUS_DATA = '0;
        chk_en = 1'b1;
        repeat (3) cyc();
        rst_n  = 1'b1;
        ENABLE = 1'b1;

        // Idle scan: digits step with zero data, one frame pulse per 16 cycles
        repeat (40) cyc();

        // Immediate update mode with the documented digit pattern
        bus_write(2'd3, 8'h00);
        bus_write(2'd0, 8'h80);
        bus_write(2'd1, 8'hCA);
        bus_write(2'd2, 8'h0A);
        repeat (20) cyc();

        // Synchronous mode: write at digit 1 commits at the wrap
        bus_write(2'd3, 8'h01);
        wait_idx(1, 1'b0);
        bus_write(2'd0, 8'h21);
        repeat (20) cyc();

        // Synchronous mode: write on the wrap edge itself
        wait_idx(3, 1'b1);
        bus_write(2'd1, 8'h5B);
        repeat (40) cyc();

        // Freeze at digit 2 for 32 cycles, then release
        wait_idx(2, 1'b0);
        bus_write(2'd3, 8'h02);
        repeat (32) cyc();
        bus_write(2'd3, 8'h00);
        repeat (10) cyc();

        // Pause mid-count, resume, then reset asynchronously mid-frame
        repeat (2) cyc();
        ENABLE = 1'b0;
        repeat (10) cyc();
        ENABLE = 1'b1;
        repeat (7) cyc();
        #2 rst_n = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (20) cyc();

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            ENABLE = ($urandom % 8) != 0;
            if ($urandom % 3 == 0) begin
                bus.BUS_ADDR = 2'($urandom % 4);
                bus.BUS_DATA = 8'($urandom);
                if (bus.BUS_ADDR == 2'd3 && ($urandom % 4) != 0)
                    bus.BUS_DATA = bus.BUS_DATA & 8'hFD;
                bus.BUS_WE = 1'b1;
            end else begin
                bus.BUS_WE = 1'b0;
            end
            if ($urandom % 300 == 0) begin
                #2 rst_n = 1'b0;
                cyc();
                rst_n = 1'b1;
            end
            cyc();
        end
        bus.BUS_WE = 1'b0;
        repeat (4) cyc();

        @(posedge CLK100_IN);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, digit-advance period in CLK100_IN cycles; simulation builds use 4.
REQ-002 CLK100_IN  input  1  system clock, 100 MHz; all logic on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ENABLE  input  1  scan enable; low freezes prescaler and digit index.
REQ-005 BUS_WE  input  1  single-cycle register write strobe.
REQ-006 BUS_ADDR  input  2  register address.
REQ-007 BUS_DATA  input  8  write data.
REQ-008 BUS_ACK  output  1  write acknowledge pulse.
REQ-009 SEG_SELECT_OUT  output  2  digit index to seven-segment decoder SEG_SELECT_IN.
REQ-010 BIN_OUT  output  4  hex nibble for the selected digit, to decoder BIN_IN.
REQ-011 DOT_OUT  output  1  decimal point for the selected digit, to decoder DOT_IN.
REQ-012 FRAME_DONE  output  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.

Function
REQ-013 Register map: addr 0 = {digit1, digit0} (digit0 in bits 3:0); addr 1 = {digit3, digit2}; addr 2 = dot mask, bits 3:0, bit n = dot of digit n, bits 7:4 ignored; addr 3 = control, bit0 SYNC, bit1 FREEZE, bits 7:2 ignored.
REQ-014 Each write to addr 0-2 SHALL load the shadow register at the clock edge where BUS_WE is sampled high.
REQ-015 Each write to addr 3 SHALL update control at that edge, taking effect in the next cycle; control is never shadowed.
REQ-016 BUS_ACK SHALL be high exactly one cycle after every cycle in which BUS_WE is high; back-to-back writes give back-to-back acks; no write is dropped.
REQ-017 SYNC=0: each write to addr 0-2 SHALL update the shadow and the active register at the same edge.
REQ-018 SYNC=1: the active registers SHALL load from the shadow only on a frame-wrap edge (index 3 -> 0).
REQ-019 SYNC=1, write coincident with a wrap edge: the commit SHALL use the pre-write shadow, and the new value SHALL commit at the next wrap.
REQ-020 Prescaler: counter width ceil(log2(REFRESH_DIV)); counts 0..REFRESH_DIV-1, then returns to 0; tick = one-cycle pulse when count equals REFRESH_DIV-1.
REQ-021 ENABLE=0: prescaler and index SHALL hold, no tick SHALL be generated, and outputs SHALL hold their last values.
REQ-022 On tick with FREEZE=0: the 2-bit index SHALL increment modulo 4.
REQ-023 On tick with FREEZE=1: the index SHALL hold, no FRAME_DONE SHALL occur, and the prescaler SHALL keep running.
REQ-024 SEG_SELECT_OUT, BIN_OUT and DOT_OUT SHALL be registered from the index and active registers, one cycle of latency after an index change.
REQ-025 Active-register changes SHALL appear on BIN_OUT and DOT_OUT one cycle after the active update, even if the index is unchanged.
REQ-026 FRAME_DONE SHALL be high in the cycle after the index edge that moves it from 3 to 0, aligned with SEG_SELECT_OUT becoming 0.
REQ-027 Clearing SYNC from 1 to 0 SHALL NOT flush pending shadow data; the shadow commits on the next write to that register or the next wrap edge, whichever comes first.

Reset
REQ-028 While rst_n is low: prescaler, index, shadow, active, control, BUS_ACK, SEG_SELECT_OUT, BIN_OUT, DOT_OUT and FRAME_DONE SHALL all be 0, regardless of clock.
REQ-029 Reset asserted mid-write or mid-frame SHALL discard pending shadow data; no ack SHALL be issued for a write sampled during reset.
REQ-030 After rst_n deasserts, the first tick SHALL occur REFRESH_DIV cycles after the first active edge.

Verification (REFRESH_DIV=4)
REQ-031 Reset, ENABLE=1, no writes -> SEG_SELECT_OUT steps 0,1,2,3,0 every 4 cycles with BIN_OUT=0 and DOT_OUT=0, and FRAME_DONE pulses once per 16 cycles.
REQ-032 SYNC=0; write addr0=0x80, addr1=0xCA, addr2=0x0A -> on digits 0..3, BIN_OUT reads 0,8,A,C and DOT_OUT reads 0,1,0,1; BUS_ACK follows each BUS_WE by 1 cycle.
REQ-033 SYNC=1; write addr0=0x21 at index 1 -> BIN_OUT is unchanged until the wrap, and from the FRAME_DONE cycle onward digit0 shows 1 and digit1 shows 2.
REQ-034 SYNC=1; write coincident with the wrap edge -> old shadow committed now, new value visible only after the following FRAME_DONE.
REQ-035 FREEZE=1 at index 2 -> SEG_SELECT_OUT stays 2 and FRAME_DONE stays 0 for 32 cycles; after FREEZE=0, index reaches 3 on the next tick.
REQ-036 ENABLE low for 10 cycles mid-count, then rst_n pulsed low mid-frame -> prescaler resumes from the held value; after reset, all outputs are 0 and the scan restarts at digit 0.
